// File: rtl/charge_pump_seq.sv
// Charge-pump phase sequencer: precharge, then sink/source pulse trains.
// Run-time lengths, mode and pair count are latched on start.
module charge_pump_seq #(
  parameter int CNT_W    = 8,
  parameter int CYC_W    = 8,
  parameter int TEST_DIV = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] pre_len,
  input  logic [CNT_W-1:0] snk_len,
  input  logic [CNT_W-1:0] src_len,
  input  logic [CYC_W-1:0] cycles,
  output logic             pre_chrg,
  output logic             snk,
  output logic             src_n,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] pair_cnt,
  output logic             rst,
  output logic             test
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SNK,
    S_SRC,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [1:0] M_ALT = 2'd0;
  localparam logic [1:0] M_SNK = 2'd1;
  localparam logic [1:0] M_SRC = 2'd2;

  localparam int TW = (TEST_DIV > 1) ? $clog2(TEST_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TEST_DIV - 1);

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt, cnt_nx, len;
  logic [CNT_W-1:0] pre_q, snk_q, src_q;
  logic [CYC_W-1:0] cyc_q, pair_nx, pair_inc;
  logic [1:0]       m_q;
  logic             load, ph_end, fin;

  logic pre_nx, snk_nx, srcn_nx;
  logic busy_nx, done_nx;

  logic [TW-1:0] tcnt;

  // GAP borrows the length of the phase it stands in for
  always_comb begin
    len = '0;
    unique case (state)
      S_PRE:   len = pre_q;
      S_SNK:   len = snk_q;
      S_SRC:   len = src_q;
      S_GAP:   len = (m_q == M_SRC) ? snk_q : src_q;
      default: len = '0;
    endcase
  end

  assign ph_end   = (cnt == len);
  assign pair_inc = pair_cnt + CYC_W'(1);
  assign fin      = (cyc_q != '0) && (pair_inc == cyc_q);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    pair_nx  = pair_cnt;
    load     = 1'b0;
    if (state == S_IDLE) begin
      if (start && !abort) begin
        load     = 1'b1;
        pair_nx  = '0;
        state_nx = S_PRE;
      end
    end else if (abort || state == S_DONE) begin
      state_nx = S_IDLE;
    end else if (ph_end) begin
      unique case (state)
        S_PRE: begin
          unique case (m_q)
            M_ALT, M_SNK: state_nx = S_SNK;
            M_SRC:        state_nx = S_GAP;
            default:      state_nx = S_DONE;
          endcase
        end
        S_SNK: begin
          state_nx = (m_q == M_ALT) ? S_SRC : S_GAP;
        end
        S_SRC: begin
          pair_nx  = pair_inc;
          state_nx = fin ? S_DONE
                   : (m_q == M_ALT) ? S_SNK : S_GAP;
        end
        S_GAP: begin
          if (m_q == M_SNK) begin
            pair_nx  = pair_inc;
            state_nx = fin ? S_DONE : S_SNK;
          end else begin
            state_nx = S_SRC;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
    if (state_nx != state || state == S_IDLE)
      cnt_nx = '0;
  end

  // outputs follow the next state so they are valid in a state's first cycle
  always_comb begin
    pre_nx  = (state_nx == S_PRE);
    snk_nx  = (state_nx == S_SNK) && !cnt_nx[0];
    srcn_nx = !((state_nx == S_SRC) && !cnt_nx[0]);
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pair_cnt <= '0;
      m_q      <= '0;
      pre_q    <= '0;
      snk_q    <= '0;
      src_q    <= '0;
      cyc_q    <= '0;
      pre_chrg <= 1'b0;
      snk      <= 1'b0;
      src_n    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pair_cnt <= pair_nx;
      pre_chrg <= pre_nx;
      snk      <= snk_nx;
      src_n    <= srcn_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      if (load) begin
        m_q   <= mode;
        pre_q <= pre_len;
        snk_q <= snk_len;
        src_q <= src_len;
        cyc_q <= cycles;
      end
    end
  end

  always_ff @(posedge clk) begin
    rst <= reset;
    if (reset) begin
      tcnt <= '0;
      test <= 1'b0;
    end else if (tcnt == T_LAST) begin
      tcnt <= '0;
      test <= !test;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

endmodule
